// File: rtl/single_port_ram.sv
// single_port_ram: write-first single-port RAM with synchronous active-low clear of data and output.
// Define SINGLE_PORT_RAM_OUT_REG_EN to add a second output register (2-cycle latency).
module single_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADD_WIDTH-1:0]  addr,
  output logic [DATA_WIDTH-1:0] wdata
);
  localparam int DEPTH = 2 ** ADD_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd;
  // Reset clears every word in the same edge, so the array is built from flops.
  always_ff @(posedge clk)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd <= '0;
    end else begin
      if (we) mem[addr] <= data;
      rd <= we ? data : mem[addr];
    end
`ifdef SINGLE_PORT_RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] pipe;
  always_ff @(posedge clk)
    pipe <= !reset ? '0 : rd;
  assign wdata = pipe;
`else
  assign wdata = rd;
`endif
endmodule

// File: tb/tb_single_port_ram.sv
// tb_single_port_ram: directed stimulus with a queue-based scoreboard checked by an independent monitor.
module tb_single_port_ram;
`ifdef SINGLE_PORT_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct {
    logic [7:0] exp;
    int         due;
    string      name;
  } item_t;
  logic       clk, reset, we;
  logic [7:0] data, wdata;
  logic [3:0] addr;
  int cyc = 0, total = 0, bad = 0;
  item_t q[$];

  single_port_ram #(.DATA_WIDTH(8), .ADD_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .we(we), .data(data), .addr(addr), .wdata(wdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    while (q.size() != 0 && q[0].due <= cyc) begin
      item_t it;
      it = q.pop_front();
      total++;
      if (wdata !== it.exp) begin
        bad++;
        $display("FAIL %s: wdata=%h expected=%h (cycle %0d)", it.name, wdata, it.exp, cyc);
      end
    end
  end

  task automatic op(input logic w, input logic [3:0] a, input logic [7:0] d,
                    input logic [7:0] e, input string n);
    item_t it;
    @(negedge clk);
    reset = 1; we = w; addr = a; data = d;
    it.exp = e; it.due = cyc + LAT; it.name = n;
    q.push_back(it);
  endtask

  task automatic rst_op(input logic w, input logic [3:0] a, input logic [7:0] d, input string n);
    item_t it;
    @(negedge clk);
    reset = 0; we = w; addr = a; data = d;
    it.exp = 8'h00; it.due = cyc + 1; it.name = n;
    q.push_back(it);
  endtask

  initial begin
    reset = 0; we = 0; addr = 0; data = 0;
    rst_op(0, 0, 0, "reset_0");
    rst_op(0, 0, 0, "reset_1");
    for (int i = 0; i < 16; i++) op(0, 4'(i), 8'h00, 8'h00, $sformatf("clear_rd_%0d", i));
    op(1, 3, 8'hA5, 8'hA5, "wr3_first");
    op(0, 3, 8'h00, 8'hA5, "rd3");
    op(1, 0, 8'h11, 8'h11, "wr0_first");
    op(1, 15, 8'hEE, 8'hEE, "wr15_first");
    op(0, 0, 8'h00, 8'h11, "rd0");
    op(0, 15, 8'h00, 8'hEE, "rd15");
    op(0, 1, 8'h00, 8'h00, "rd1_unwritten");
    op(1, 7, 8'h3C, 8'h3C, "wr7_first");
    op(0, 7, 8'h00, 8'h3C, "rd7");
    op(1, 5, 8'hFF, 8'hFF, "wr5_first");
    rst_op(0, 5, 8'h00, "mid_reset");
    op(0, 5, 8'h00, 8'h00, "rd5_after_reset");
    op(0, 3, 8'h00, 8'h00, "rd3_after_reset");
    rst_op(1, 2, 8'h77, "reset_with_write");
    op(0, 2, 8'h00, 8'h00, "rd2_lost_write");
    op(1, 9, 8'h5A, 8'h5A, "wr9_first");
    op(0, 9, 8'h00, 8'h5A, "rd9_back_to_back");
    op(0, 15, 8'h00, 8'h00, "rd15_after_reset");
    @(negedge clk);
    we = 0;
    repeat (LAT + 3) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
